// File: rtl/lbp_hist_if.sv
// LBP histogram bus: result strobes from the LBP engine in, histogram beats
// and status out. The master side is the engine/readout sink.
interface lbp_hist_if;
  logic        lbp_valid;
  logic [13:0] lbp_addr;
  logic [7:0]  lbp_data;
  logic        finish;
  logic        init_done;
  logic        hist_valid;
  logic        hist_ready;
  logic [7:0]  hist_bin;
  logic [13:0] hist_count;
  logic        hist_last;
  logic [13:0] pix_total;
  logic        err;
  logic        done;

  modport master (
    output lbp_valid, lbp_addr, lbp_data, finish, hist_ready,
    input  init_done, hist_valid, hist_bin, hist_count, hist_last, pix_total, err, done
  );
  modport slave (
    input  lbp_valid, lbp_addr, lbp_data, finish, hist_ready,
    output init_done, hist_valid, hist_bin, hist_count, hist_last, pix_total, err, done
  );
endinterface

// File: rtl/lbp_hist.sv
// 256-bin LBP code histogram: clears, accumulates strobes through a forwarded
// read-modify-write pipeline, then streams the bins out with ready/valid.
module lbp_hist (
  input  logic       clk,
  input  logic       reset,
  lbp_hist_if.slave  bus
);
  typedef enum logic [2:0] {CLEAR, ACCUM, FLUSH, OUT, DONE} state_t;
  localparam logic [13:0] CMAX = 14'h3FFF;

  state_t      state_q, state_d;
  logic [7:0]  clr_idx_q, clr_idx_d;
  logic [1:0]  flush_cnt_q, flush_cnt_d;
  logic        s2_vld_q, s2_vld_d;
  logic [7:0]  s2_bin_q, s2_bin_d;
  logic [13:0] s2_cnt_q, s2_cnt_d;
  logic [13:0] pix_total_q, pix_total_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic        hist_valid_q, hist_valid_d;
  logic [7:0]  hist_bin_q, hist_bin_d;
  logic [13:0] hist_count_q, hist_count_d;
  logic        hist_last_q, hist_last_d;

  logic [13:0] mem [256];
  logic        mem_we;
  logic [7:0]  mem_waddr;
  logic [13:0] mem_wdata;
  logic        accept, border;
  logic [13:0] base;
  logic [7:0]  rd_bin;

  always_comb begin
    state_d      = state_q;
    clr_idx_d    = clr_idx_q;
    flush_cnt_d  = flush_cnt_q;
    s2_vld_d     = 1'b0;
    s2_bin_d     = s2_bin_q;
    s2_cnt_d     = s2_cnt_q;
    pix_total_d  = pix_total_q;
    err_d        = err_q;
    done_d       = done_q;
    hist_valid_d = hist_valid_q;
    hist_bin_d   = hist_bin_q;
    hist_count_d = hist_count_q;
    hist_last_d  = hist_last_q;
    mem_we       = s2_vld_q;
    mem_waddr    = s2_bin_q;
    mem_wdata    = s2_cnt_q;
    accept       = 1'b0;
    rd_bin       = 8'd0;
    border = (bus.lbp_addr[6:0] == 7'd0) || (bus.lbp_addr[6:0] == 7'd127) ||
             (bus.lbp_addr[13:7] == 7'd0) || (bus.lbp_addr[13:7] == 7'd127);
    // Stage 2 has not written yet, so a same-bin hit must take its result.
    base = (s2_vld_q && s2_bin_q == bus.lbp_data) ? s2_cnt_q : mem[bus.lbp_data];

    unique case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_idx_q;
        mem_wdata = 14'd0;
        clr_idx_d = clr_idx_q + 8'd1;
        if (clr_idx_q == 8'hFF) state_d = ACCUM;
        if (bus.lbp_valid) err_d = 1'b1;
      end
      ACCUM: begin
        accept      = bus.lbp_valid;
        flush_cnt_d = 2'd0;
        if (bus.finish) state_d = FLUSH;
      end
      FLUSH: begin
        // Third cycle takes no strobe so the last write lands before readout.
        accept      = bus.lbp_valid && (flush_cnt_q != 2'd2);
        flush_cnt_d = flush_cnt_q + 2'd1;
        if (flush_cnt_q == 2'd2) state_d = OUT;
      end
      OUT: begin
        if (bus.lbp_valid) err_d = 1'b1;
        if (!hist_valid_q || bus.hist_ready) begin
          if (hist_valid_q && hist_last_q) begin
            hist_valid_d = 1'b0;
            done_d       = 1'b1;
            state_d      = DONE;
          end else begin
            rd_bin       = hist_valid_q ? hist_bin_q + 8'd1 : 8'd0;
            hist_valid_d = 1'b1;
            hist_bin_d   = rd_bin;
            hist_count_d = mem[rd_bin];
            hist_last_d  = (rd_bin == 8'hFF);
          end
        end
      end
      DONE: begin
        if (bus.lbp_valid) err_d = 1'b1;
      end
      default: state_d = CLEAR;
    endcase

    if (accept) begin
      s2_vld_d = 1'b1;
      s2_bin_d = bus.lbp_data;
      if (base == CMAX) begin
        s2_cnt_d = CMAX;
        err_d    = 1'b1;
      end else begin
        s2_cnt_d = base + 14'd1;
      end
      if (pix_total_q != CMAX) pix_total_d = pix_total_q + 14'd1;
      if (border) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= CLEAR;
      clr_idx_q    <= 8'd0;
      flush_cnt_q  <= 2'd0;
      s2_vld_q     <= 1'b0;
      s2_bin_q     <= 8'd0;
      s2_cnt_q     <= 14'd0;
      pix_total_q  <= 14'd0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      hist_valid_q <= 1'b0;
      hist_bin_q   <= 8'd0;
      hist_count_q <= 14'd0;
      hist_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      flush_cnt_q  <= flush_cnt_d;
      s2_vld_q     <= s2_vld_d;
      s2_bin_q     <= s2_bin_d;
      s2_cnt_q     <= s2_cnt_d;
      pix_total_q  <= pix_total_d;
      err_q        <= err_d;
      done_q       <= done_d;
      hist_valid_q <= hist_valid_d;
      hist_bin_q   <= hist_bin_d;
      hist_count_q <= hist_count_d;
      hist_last_q  <= hist_last_d;
    end
  end

  // Bin storage has no reset; CLEAR initialises it.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign bus.init_done  = (state_q != CLEAR);
  assign bus.hist_valid = hist_valid_q;
  assign bus.hist_bin   = hist_bin_q;
  assign bus.hist_count = hist_count_q;
  assign bus.hist_last  = hist_last_q;
  assign bus.pix_total  = pix_total_q;
  assign bus.err        = err_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_lbp_hist.sv
// Directed bench for lbp_hist: strobe bursts from a vector table, full
// readouts with random backpressure, saturation, border and reset corners.
module tb_lbp_hist;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lbp_hist_if bus();
  lbp_hist dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [7:0]  data;
    int          n;
    int          gap;
    logic [13:0] exp;
  } vec_t;

  localparam logic [13:0] INTERIOR = {7'd64, 7'd64};

  int checks = 0;
  int failures = 0;
  logic [13:0] got  [256];
  logic [13:0] expv [256];
  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.lbp_valid  = 1'b0;
    bus.lbp_addr   = 14'd0;
    bus.lbp_data   = 8'd0;
    bus.finish     = 1'b0;
    bus.hist_ready = 1'b0;
  endtask

  // Called at a negedge; checks the asynchronous clear before any clock edge.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    drive_idle();
    #1;
    check({tag, "_rst_init_done"},  32'(bus.init_done),  0);
    check({tag, "_rst_hist_valid"}, 32'(bus.hist_valid), 0);
    check({tag, "_rst_hist_bin"},   32'(bus.hist_bin),   0);
    check({tag, "_rst_hist_count"}, 32'(bus.hist_count), 0);
    check({tag, "_rst_hist_last"},  32'(bus.hist_last),  0);
    check({tag, "_rst_pix_total"},  32'(bus.pix_total),  0);
    check({tag, "_rst_err"},        32'(bus.err),        0);
    check({tag, "_rst_done"},       32'(bus.done),       0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_init(input string tag, input int start);
    int n = start;
    while (!bus.init_done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_init_latency"}, 32'(n), 256);
  endtask

  task automatic strobe(input logic [7:0] data, input logic [13:0] addr);
    bus.lbp_valid = 1'b1;
    bus.lbp_data  = data;
    bus.lbp_addr  = addr;
    @(negedge clk);
    bus.lbp_valid = 1'b0;
  endtask

  // Pulses finish (optionally with bin-0x55 strobes in the finish cycle and the
  // two accepting flush cycles) and collects all 256 beats into got[].
  task automatic run_readout(input string tag, input bit rnd, input bit fs);
    int n = 0;
    int idx = 0;
    bit fin = 1'b0;
    bit first = 1'b1;
    bit pv = 1'b0;
    bit pr = 1'b0;
    bit r;
    logic [22:0] prev = '0;
    bus.finish    = 1'b1;
    bus.lbp_valid = fs;
    bus.lbp_data  = 8'h55;
    bus.lbp_addr  = INTERIOR;
    while (!fin && n < 3000) begin
      @(negedge clk);
      n++;
      bus.finish    = 1'b0;
      bus.lbp_valid = fs && (n <= 2);
      if (bus.hist_valid) begin
        if (first) begin
          check({tag, "_first_beat_latency"}, 32'(n), 5);
          first = 1'b0;
        end
        if (pv && !pr)
          check({tag, "_stall_stable"}, 32'({bus.hist_bin, bus.hist_count, bus.hist_last}), 32'(prev));
        r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.hist_ready = r;
        if (r) begin
          check({tag, "_beat_order"}, 32'(bus.hist_bin), 32'(idx));
          check({tag, "_beat_last"}, 32'(bus.hist_last), 32'(idx == 255));
          got[idx] = bus.hist_count;
          if (idx == 255) fin = 1'b1;
          idx++;
        end
        pv = 1'b1;
        pr = r;
        prev = {bus.hist_bin, bus.hist_count, bus.hist_last};
      end else begin
        bus.hist_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        pv = 1'b0;
      end
    end
    if (!fin) check({tag, "_readout_timeout_beats"}, 32'(idx), 256);
    @(negedge clk);
    bus.hist_ready = 1'b0;
    check({tag, "_done_valid"}, 32'(bus.hist_valid), 0);
    check({tag, "_done"}, 32'(bus.done), 1);
  endtask

  task automatic check_bins(input string tag);
    int bad = 0;
    for (int i = 0; i < 256; i++) if (got[i] !== expv[i]) bad++;
    check({tag, "_bins_wrong"}, 32'(bad), 0);
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 256; i++) expv[i] = 14'd0;
  endtask

  initial begin
    int n;
    drive_idle();
    vecs[0] = '{8'h3C, 5, 0, 14'd7};
    vecs[1] = '{8'h3D, 1, 0, 14'd1};
    vecs[2] = '{8'h3C, 2, 1, 14'd7};
    vecs[3] = '{8'h00, 3, 2, 14'd4};
    vecs[4] = '{8'h80, 1, 0, 14'd1};
    vecs[5] = '{8'h00, 1, 0, 14'd4};
    vecs[6] = '{8'hFF, 2, 0, 14'd2};
    vecs[7] = '{8'hFE, 1, 3, 14'd1};
    @(negedge clk);

    // Empty image: all-zero readout, then a strobe in DONE is flagged only.
    do_reset("empty");
    wait_init("empty", 0);
    clear_exp();
    run_readout("empty", 1'b0, 1'b0);
    check_bins("empty");
    check("empty_err", 32'(bus.err), 0);
    check("empty_pix", 32'(bus.pix_total), 0);
    strobe(8'h01, INTERIOR);
    check("done_strobe_err", 32'(bus.err), 1);
    check("done_strobe_pix", 32'(bus.pix_total), 0);
    check("done_held", 32'(bus.done), 1);

    // Vector table with back-to-back and gapped hits, plus flush-window strobes.
    do_reset("mix");
    wait_init("mix", 0);
    clear_exp();
    for (int v = 0; v < 8; v++) begin
      repeat (vecs[v].n) strobe(vecs[v].data, INTERIOR);
      repeat (vecs[v].gap) @(negedge clk);
      expv[vecs[v].data] = vecs[v].exp;
    end
    expv[8'h55] = 14'd3;
    run_readout("mix", 1'b1, 1'b1);
    for (int v = 0; v < 8; v++)
      check($sformatf("mix_bin_%02h", vecs[v].data), 32'(got[vecs[v].data]), 32'(vecs[v].exp));
    check("mix_bin_55_flush", 32'(got[8'h55]), 3);
    check_bins("mix");
    check("mix_pix", 32'(bus.pix_total), 19);
    check("mix_err", 32'(bus.err), 0);

    // Reset mid-readout, strobe during CLEAR, then an all-zero readout.
    do_reset("mid");
    wait_init("mid", 0);
    repeat (4) strobe(8'h07, INTERIOR);
    bus.hist_ready = 1'b1;
    bus.finish = 1'b1;
    @(negedge clk);
    bus.finish = 1'b0;
    n = 0;
    while (!(bus.hist_valid && bus.hist_bin == 8'd100) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("mid_reach_bin100", 32'(bus.hist_bin), 100);
    do_reset("mid_out");
    strobe(8'h33, INTERIOR);
    check("clear_strobe_err", 32'(bus.err), 1);
    wait_init("mid_rerun", 1);
    clear_exp();
    run_readout("mid_rerun", 1'b0, 1'b0);
    check_bins("mid_rerun");
    check("mid_rerun_pix", 32'(bus.pix_total), 0);

    // Every interior pixel on bin 255.
    do_reset("full");
    wait_init("full", 0);
    for (int y = 1; y <= 126; y++)
      for (int x = 1; x <= 126; x++)
        strobe(8'hFF, {7'(y), 7'(x)});
    clear_exp();
    expv[255] = 14'd15876;
    run_readout("full", 1'b0, 1'b0);
    check("full_bin_ff", 32'(got[255]), 15876);
    check_bins("full");
    check("full_pix", 32'(bus.pix_total), 15876);
    check("full_err", 32'(bus.err), 0);

    // Saturation of one bin and of pix_total.
    do_reset("sat");
    wait_init("sat", 0);
    repeat (16390) strobe(8'h00, INTERIOR);
    clear_exp();
    expv[0] = 14'd16383;
    run_readout("sat", 1'b0, 1'b0);
    check("sat_bin_0", 32'(got[0]), 16383);
    check_bins("sat");
    check("sat_pix", 32'(bus.pix_total), 16383);
    check("sat_err", 32'(bus.err), 1);

    // Border pixels are flagged but still counted.
    do_reset("border");
    wait_init("border", 0);
    strobe(8'h10, INTERIOR);
    check("border_interior_err", 32'(bus.err), 0);
    strobe(8'h10, {7'd5, 7'd0});
    check("border_x0_err", 32'(bus.err), 1);
    strobe(8'h10, {7'd127, 7'd5});
    check("border_pix", 32'(bus.pix_total), 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lbp_hist.md
LBP_HIST -- requirements
Module: lbp_hist

Interface
REQ-001 SHALL have port clk, input, 1 bit: clock; all flops rise-edge triggered.
REQ-002 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port lbp_valid, input, 1 bit: LBP result strobe from the LBP engine.
REQ-004 SHALL have port lbp_addr, input, 14 bits: pixel address {y,x}; carried for range check only.
REQ-005 SHALL have port lbp_data, input, 8 bits: LBP code, used as the bin index.
REQ-006 SHALL have port finish, input, 1 bit: engine end-of-image indication.
REQ-007 SHALL have port init_done, output, 1 bit: histogram cleared; system gates gray_ready with it.
REQ-008 SHALL have port hist_valid, output, 1 bit: readout beat valid.
REQ-009 SHALL have port hist_ready, input, 1 bit: readout sink ready.
REQ-010 SHALL have port hist_bin, output, 8 bits: bin index of the current beat.
REQ-011 SHALL have port hist_count, output, 14 bits: count for hist_bin.
REQ-012 SHALL have port hist_last, output, 1 bit: high on the bin-255 beat.
REQ-013 SHALL have port pix_total, output, 14 bits: number of accepted lbp_valid strobes.
REQ-014 SHALL have port err, output, 1 bit: sticky error flag.
REQ-015 SHALL have port done, output, 1 bit: readout complete; held until reset.

Function
REQ-016 SHALL hold 256 bins x 14-bit counters in an internal array.
REQ-017 SHALL implement states CLEAR, ACCUM, FLUSH, OUT, DONE.
REQ-018 SHALL enter CLEAR on reset and zero one bin per cycle, bins 0..255, in exactly 256 cycles, then go to ACCUM.
REQ-019 SHALL drive init_done=1 only in ACCUM, FLUSH, OUT and DONE.
REQ-020 SHALL ignore lbp_valid in CLEAR (no bin or pix_total change) and set err.
REQ-021 SHALL, in ACCUM and FLUSH, increment bin[lbp_data] and pix_total per lbp_valid; accept one strobe per cycle with no backpressure.
REQ-022 SHALL use a 2-stage read-modify-write pipeline: stage 1 reads the bin, stage 2 writes count+1.
REQ-023 SHALL forward the stage-2 result when consecutive strobes hit the same bin, so N back-to-back hits add exactly N.
REQ-024 SHALL saturate any bin at 16383 and set err on an increment that would exceed it; pix_total SHALL saturate at 16383 likewise.
REQ-025 SHALL set err on lbp_valid with lbp_addr[6:0] or lbp_addr[13:7] equal to 0 or 127 (border pixel), and still count it.
REQ-026 SHALL go ACCUM->FLUSH on finish=1; FLUSH lasts 3 cycles, accepts lbp_valid in its first 2 cycles and drains the pipeline in the third.
REQ-027 SHALL go FLUSH->OUT and emit bins 0..255 in ascending order from registered outputs, with first hist_valid in the cycle after entering OUT.
REQ-028 SHALL transfer a beat when hist_valid&&hist_ready; hist_bin, hist_count and hist_last SHALL stay stable while hist_valid&&!hist_ready.
REQ-029 SHALL support one beat per cycle with hist_ready held high, for 256 consecutive beats.
REQ-030 SHALL go OUT->DONE after the bin-255 beat transfers; in DONE, hist_valid=0 and done=1.
REQ-031 SHALL ignore lbp_valid in OUT and DONE and set err; SHALL ignore finish outside ACCUM.
REQ-032 SHALL clear err only by reset.

Reset
REQ-033 SHALL, on reset assertion at any time (including mid-ACCUM or mid-OUT), immediately force state CLEAR, init_done=0, hist_valid=0, hist_bin=0, hist_count=0, hist_last=0, pix_total=0, err=0, done=0, and clear pipeline valids.
REQ-034 SHALL treat bin contents as don't-care until the post-reset CLEAR completes.

Verification
REQ-035 SHALL pass: release reset, no strobes -> init_done rises exactly 256 cycles later; finish then gives 256 beats, all hist_count=0, hist_last only on bin 255.
REQ-036 SHALL pass: 15876 interior strobes with lbp_data=8'hFF, then finish -> bin 255=15876, others 0, pix_total=15876, err=0.
REQ-037 SHALL pass: 5 back-to-back strobes on bin 8'h3C, then 1 on 8'h3D, 2 on 8'h3C -> bin 3C=7, bin 3D=1.
REQ-038 SHALL pass: hist_ready random 50% during OUT -> every bin appears once, in order, with stable data under stall; done=1 after bin 255.
REQ-039 SHALL pass: 16390 strobes on bin 0 -> bin 0=16383, err=1.
REQ-040 SHALL pass: reset asserted at bin 100 of OUT -> outputs zero at once, CLEAR re-runs, all bins read 0 after the next finish.
